note_chart_scheduler: RTL

Sequences a rhythm-game chart against the running frame counter. Fetches timed note entries from a synchronous chart ROM and spawns each one to the renderer a fixed lead time before it is due. Holds one pending note per lane, judges lane key presses as hits or misses, and keeps score and combo. Sits between the frame-time counter (deltatime source), the USB key decoder and the chart ROM, all in the Master_Clk domain.

---
 rtl/rhythm_pkg.sv | 26 ++
 rtl/lane_judge.sv | 66 ++++++
 rtl/note_chart_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rhythm_pkg.sv
// Shared types for the note chart scheduler: chart entry layout, FSM states
// and score weights.
package rhythm_pkg;

  localparam int unsigned SCORE_PERFECT = 3;
  localparam int unsigned SCORE_HIT     = 1;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_TIME_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } sched_state_e;

  // Chart ROM word for the default lane/time widths ('last' is the end flag)
  typedef struct packed {
    logic                  last;
    logic [DEF_LANES-1:0]  lane_mask;
    logic [DEF_TIME_W-1:0] note_time;
  } chart_entry_t;

endpackage

// File: rtl/lane_judge.sv
// Per-lane judge: holds one pending note, edge-detects the lane key and
// classifies presses and frame ticks as hit, perfect or miss.
module lane_judge
  import rhythm_pkg::*;
#(
  parameter int unsigned TIME_W  = 13,
  parameter int unsigned HIT_WIN = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              key_i,
  input  logic              frame_tick_i,
  input  logic [TIME_W-1:0] now_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_time_i,
  output logic              hit_o,
  output logic              perfect_o,
  output logic              miss_o,
  output logic              busy_o
);

  logic              key_q;
  logic              valid_q, valid_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] diff;
  logic [TIME_W:0]   late_lim;
  logic              press, in_win, late;

  assign press    = key_i & ~key_q;
  assign diff     = (now_i >= time_q) ? (now_i - time_q) : (time_q - now_i);
  assign in_win   = diff <= TIME_W'(HIT_WIN);
  assign late_lim = {1'b0, time_q} + (TIME_W+1)'(HIT_WIN);
  assign late     = {1'b0, now_i} > late_lim;

  // A hit on this lane takes precedence over a miss in the same cycle
  assign hit_o     = en_i & valid_q & press & in_win;
  assign perfect_o = hit_o & (now_i == time_q);
  assign miss_o    = en_i & valid_q & frame_tick_i & late & ~hit_o;
  assign busy_o    = valid_q;

  always_comb begin
    valid_d = valid_q;
    time_d  = time_q;
    if (clr_i || hit_o || miss_o) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      time_d  = load_time_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q   <= 1'b0;
      valid_q <= 1'b0;
      time_q  <= '0;
    end else begin
      key_q   <= key_i;
      valid_q <= valid_d;
      time_q  <= time_d;
    end
  end

endmodule

// File: rtl/note_chart_scheduler.sv
// Rhythm-game chart sequencer: fetches chart entries, spawns notes a fixed
// lead ahead of their due frame, and accumulates score and combo.
module note_chart_scheduler
  import rhythm_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned TIME_W     = 13,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned HIT_WIN    = 4,
  parameter int unsigned SPAWN_LEAD = 64
) (
  input  logic                    Master_Clk,
  input  logic                    Game_Reset_n,
  input  logic                    game_active,
  input  logic                    frame_tick,
  input  logic [TIME_W-1:0]       deltatime,
  input  logic [LANES-1:0]        key_press,
  output logic [ADDR_W-1:0]       chart_addr,
  input  logic [LANES+TIME_W:0]   chart_data,
  output logic                    spawn_valid,
  output logic [LANES-1:0]        spawn_lanes,
  output logic [TIME_W-1:0]       spawn_time,
  output logic [LANES-1:0]        hit_pulse,
  output logic [LANES-1:0]        perfect_pulse,
  output logic [LANES-1:0]        miss_pulse,
  output logic [15:0]             score,
  output logic [7:0]              combo,
  output logic                    chart_done
);

  sched_state_e      state_q, state_d;
  logic              active_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              spawn, start;

  logic              e_last;
  logic [LANES-1:0]  e_mask;
  logic [TIME_W-1:0] e_time;
  logic              due, lanes_free;

  logic [LANES-1:0]  lane_hit, lane_perf, lane_miss, lane_busy;

  logic              spawn_valid_q;
  logic [LANES-1:0]  spawn_lanes_q;
  logic [TIME_W-1:0] spawn_time_q;
  logic [LANES-1:0]  hit_q, perf_q, miss_q;
  logic [15:0]       score_q, score_d, gain;
  logic [7:0]        combo_q, combo_d;
  logic [7:0]        n_hit, n_perf;
  logic [16:0]       score_sum;
  logic [8:0]        combo_sum;

  assign e_last     = chart_data[LANES+TIME_W];
  assign e_mask     = chart_data[LANES+TIME_W-1:TIME_W];
  assign e_time     = chart_data[TIME_W-1:0];
  assign due        = ({1'b0, deltatime} + (TIME_W+1)'(SPAWN_LEAD)) >= {1'b0, e_time};
  // busy is the registered slot state, so a lane freed this cycle is only reusable next cycle
  assign lanes_free = (lane_busy & e_mask) == '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    spawn   = 1'b0;
    start   = 1'b0;
    if (!game_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!active_q) begin
            start   = 1'b1;
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_CHECK;
        ST_CHECK: begin
          if (e_last || e_mask == '0) begin
            state_d = ST_DONE;
          end else if (due && lanes_free) begin
            spawn = 1'b1;
            if (addr_q == '1) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(
      .TIME_W (TIME_W),
      .HIT_WIN(HIT_WIN)
    ) u_judge (
      .clk_i       (Master_Clk),
      .rst_ni      (Game_Reset_n),
      .en_i        (game_active),
      .clr_i       (~game_active | start),
      .key_i       (key_press[g]),
      .frame_tick_i(frame_tick),
      .now_i       (deltatime),
      .load_i      (spawn & e_mask[g]),
      .load_time_i (e_time),
      .hit_o       (lane_hit[g]),
      .perfect_o   (lane_perf[g]),
      .miss_o      (lane_miss[g]),
      .busy_o      (lane_busy[g])
    );
  end

  always_comb begin
    n_hit  = '0;
    n_perf = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_hit  = n_hit + 8'(lane_hit[i]);
      n_perf = n_perf + 8'(lane_perf[i]);
    end
    gain      = 16'(n_perf) * 16'(SCORE_PERFECT) + 16'(n_hit - n_perf) * 16'(SCORE_HIT);
    score_sum = {1'b0, score_q} + {1'b0, gain};
    combo_sum = {1'b0, combo_q} + {1'b0, n_hit};
    score_d   = score_sum[16] ? '1 : score_sum[15:0];
    if (|lane_miss) begin
      combo_d = '0;
    end else begin
      combo_d = combo_sum[8] ? '1 : combo_sum[7:0];
    end
    if (start) begin
      score_d = '0;
      combo_d = '0;
    end
  end

  always_ff @(posedge Master_Clk or negedge Game_Reset_n) begin
    if (!Game_Reset_n) begin
      state_q       <= ST_IDLE;
      active_q      <= 1'b0;
      addr_q        <= '0;
      spawn_valid_q <= 1'b0;
      spawn_lanes_q <= '0;
      spawn_time_q  <= '0;
      hit_q         <= '0;
      perf_q        <= '0;
      miss_q        <= '0;
      score_q       <= '0;
      combo_q       <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= game_active;
      addr_q        <= addr_d;
      spawn_valid_q <= spawn;
      spawn_lanes_q <= spawn ? e_mask : '0;
      spawn_time_q  <= spawn ? e_time : '0;
      hit_q         <= lane_hit;
      perf_q        <= lane_perf;
      miss_q        <= lane_miss;
      score_q       <= score_d;
      combo_q       <= combo_d;
    end
  end

  assign chart_addr    = addr_q;
  assign spawn_valid   = spawn_valid_q;
  assign spawn_lanes   = spawn_lanes_q;
  assign spawn_time    = spawn_time_q;
  assign hit_pulse     = hit_q;
  assign perfect_pulse = perf_q;
  assign miss_pulse    = miss_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign chart_done    = (state_q == ST_DONE) && (lane_busy == '0);

endmodule
